// File: rtl/rsa_arbiter.sv
// Round-robin arbiter sharing one RSA modexp engine among N_REQ requesters, one job in flight.
// Optional macro RSA_ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin ports.
module rsa_arbiter #(
   parameter int N_REQ = 4,
   parameter int KEY_W = 256,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*KEY_W-1:0] req_msg,
   input  logic [N_REQ*KEY_W-1:0] req_key,
   input  logic [N_REQ*KEY_W-1:0] req_modulus,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [KEY_W-1:0]       rsp_crypto,
   output logic                   eng_i_valid,
   input  logic                   eng_i_ready,
   output logic [KEY_W-1:0]       eng_msg,
   output logic [KEY_W-1:0]       eng_key,
   output logic [KEY_W-1:0]       eng_modulus,
   input  logic                   eng_o_valid,
   output logic                   eng_o_ready,
   input  logic [KEY_W-1:0]       eng_crypto,
   output logic                   busy,
   output logic [ID_W-1:0]        grant_id
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   state_t           state_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  rr_ptr_d;
   logic [ID_W-1:0]  grant_id_q;
   logic [KEY_W-1:0] msg_q;
   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] mod_q;
   logic [KEY_W-1:0] res_q;

   logic             win_vld;
   logic [ID_W-1:0]  win_id;
   int               idx;

   // Scan offsets high to low so the lowest offset from rr_ptr_q is the last (winning) assignment.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
`ifdef RSA_ARB_PRIO0_EN
         if (idx != 0 && req_valid[idx]) begin
`else
         if (req_valid[idx]) begin
`endif
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
`ifdef RSA_ARB_PRIO0_EN
      if (req_valid[0]) begin
         win_vld = 1'b1;
         win_id  = '0;
      end
`endif
   end

   always_comb begin
      rr_ptr_d = ID_W'((int'(grant_id_q) + 1) % N_REQ);
   end

   assign req_ready   = (state_q == S_IDLE && win_vld) ? (ONE << win_id) : '0;
   assign rsp_valid   = (state_q == S_RETURN) ? (ONE << grant_id_q) : '0;
   assign rsp_crypto  = res_q;
   assign eng_i_valid = (state_q == S_ISSUE);
   assign eng_o_ready = (state_q == S_WAIT);
   assign eng_msg     = msg_q;
   assign eng_key     = key_q;
   assign eng_modulus = mod_q;
   assign busy        = (state_q != S_IDLE);
   assign grant_id    = grant_id_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         msg_q      <= '0;
         key_q      <= '0;
         mod_q      <= '0;
         res_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_vld) begin
                  msg_q      <= req_msg[int'(win_id)*KEY_W +: KEY_W];
                  key_q      <= req_key[int'(win_id)*KEY_W +: KEY_W];
                  mod_q      <= req_modulus[int'(win_id)*KEY_W +: KEY_W];
                  grant_id_q <= win_id;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (eng_i_ready) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_o_valid) begin
                  res_q   <= eng_crypto;
                  state_q <= S_RETURN;
               end
            end
            S_RETURN: begin
               if (rsp_ready[int'(grant_id_q)]) begin
                  state_q <= S_IDLE;
`ifdef RSA_ARB_PRIO0_EN
                  if (grant_id_q != '0) rr_ptr_q <= rr_ptr_d;
`else
                  rr_ptr_q <= rr_ptr_d;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
